// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the rst_seq reset sequencer.
package rst_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        SEQ       = 2'd1,
        RUN       = 2'd2
    } state_t;

    function automatic int cnt_w(input int stage_dly);
        return (stage_dly < 1) ? 1 : $clog2(stage_dly + 1);
    endfunction

endpackage

// File: rtl/rst_seq_lockfilt.sv
// PLL lock synchroniser plus saturating "lock has been stable" filter.
module rst_seq_lockfilt #(
    parameter int LOCK_FILT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pll_lock,
    output logic lock_s,
    output logic lock_ok
);

    localparam int FW = $clog2(LOCK_FILT + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILT);

    logic          sync_q;
    logic [FW-1:0] filt_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= 1'b0;
            lock_s   <= 1'b0;
            filt_cnt <= '0;
        end else begin
            sync_q <= pll_lock;
            lock_s <= sync_q;
            if (!lock_s)
                filt_cnt <= '0;
            else if (filt_cnt != FILT_MAX)
                filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign lock_ok = (filt_cnt == FILT_MAX);

endmodule

// File: rtl/rst_seq.sv
// Multi-domain reset sequencer: filtered PLL lock, then ordered channel release.
// Optional watchdog re-sequencing is built only when RST_SEQ_WDT_EN is defined.
//
//   state     | meaning
//   WAIT_LOCK | all channels held, waiting for a filtered PLL lock
//   SEQ       | releasing channel `stage` after STAGE_DLY unheld cycles
//   RUN       | every channel released
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int STAGE_DLY  = 255,
    parameter int LOCK_FILT  = 4,
    parameter int WDT_CYCLES = 24000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_lock,
    input  logic [NUM_CH-1:0]  ch_hold,
    input  logic               sw_req,
    input  logic               wdt_kick,
    output logic [NUM_CH-1:0]  ch_reset,
    output logic               all_done,
    output logic               wdt_flag,
    output logic [STATE_W-1:0] state_o
);

    localparam int CW = cnt_w(STAGE_DLY);
    localparam int KW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] DLY_LAST = CW'(STAGE_DLY - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(NUM_CH - 1);

    state_t            state, state_nx;
    logic [KW-1:0]     stage, stage_nx;
    logic [CW-1:0]     dly_cnt, dly_cnt_nx;
    logic [NUM_CH-1:0] ch_reset_nx;
    logic              all_done_nx;
    logic              lock_s, lock_ok;
    logic              restart;

    rst_seq_lockfilt #(.LOCK_FILT(LOCK_FILT)) u_lockfilt (
        .clk      (clk),
        .reset_n  (reset_n),
        .pll_lock (pll_lock),
        .lock_s   (lock_s),
        .lock_ok  (lock_ok)
    );

`ifdef RST_SEQ_WDT_EN
    localparam int WW = $clog2(WDT_CYCLES + 1);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

    logic [WW-1:0] wdt_cnt;
    logic          wdt_fire;

    // A kick in the expiry cycle suppresses the fire.
    assign wdt_fire = (state == RUN) && !wdt_kick && (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdt_cnt  <= '0;
            wdt_flag <= 1'b0;
        end else begin
            if (state != RUN || wdt_kick || wdt_fire)
                wdt_cnt <= '0;
            else
                wdt_cnt <= wdt_cnt + WW'(1);
            if (wdt_fire)
                wdt_flag <= 1'b1;
        end
    end

    assign restart = sw_req | wdt_fire;
`else
    localparam int unused_wdt_cycles = WDT_CYCLES;
    logic unused_kick;
    assign unused_kick = wdt_kick;
    assign wdt_flag    = 1'b0;
    assign restart     = sw_req;
`endif

    always_comb begin
        state_nx    = state;
        stage_nx    = stage;
        dly_cnt_nx  = dly_cnt;
        ch_reset_nx = ch_reset;
        all_done_nx = all_done;
        case (state)
            WAIT_LOCK: begin
                ch_reset_nx = '1;
                all_done_nx = 1'b0;
                if (lock_ok) begin
                    state_nx   = SEQ;
                    stage_nx   = '0;
                    dly_cnt_nx = '0;
                end
            end
            SEQ, RUN: begin
                // Lock loss outranks any restart request.
                if (!lock_s || restart) begin
                    state_nx    = lock_s ? SEQ : WAIT_LOCK;
                    ch_reset_nx = '1;
                    all_done_nx = 1'b0;
                    stage_nx    = '0;
                    dly_cnt_nx  = '0;
                end else if (state == SEQ) begin
                    if (ch_hold[stage]) begin
                        dly_cnt_nx = '0;
                    end else if (dly_cnt == DLY_LAST) begin
                        ch_reset_nx[stage] = 1'b0;
                        dly_cnt_nx         = '0;
                        if (stage == K_LAST) begin
                            state_nx    = RUN;
                            all_done_nx = 1'b1;
                        end else begin
                            stage_nx = stage + KW'(1);
                        end
                    end else begin
                        dly_cnt_nx = dly_cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nx    = WAIT_LOCK;
                ch_reset_nx = '1;
                all_done_nx = 1'b0;
                stage_nx    = '0;
                dly_cnt_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= WAIT_LOCK;
            stage    <= '0;
            dly_cnt  <= '0;
            ch_reset <= '1;
            all_done <= 1'b0;
        end else begin
            state    <= state_nx;
            stage    <= stage_nx;
            dly_cnt  <= dly_cnt_nx;
            ch_reset <= ch_reset_nx;
            all_done <= all_done_nx;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq with 3 channels, 4-cycle spacing, 2-sample lock filter,
// 20-cycle watchdog (watchdog scenarios depend on RST_SEQ_WDT_EN).
module tb_rst_seq;

    localparam int NCH = 3;
    localparam int SD  = 4;
    localparam int LF  = 2;
    localparam int WDT = 20;

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_SEQ  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic           clk;
    logic           reset_n;
    logic           pll_lock;
    logic [NCH-1:0] ch_hold;
    logic           sw_req;
    logic           wdt_kick;
    logic [NCH-1:0] ch_reset;
    logic           all_done;
    logic           wdt_flag;
    logic [1:0]     state_o;

    int n_checks = 0;
    int n_pass   = 0;
    int rel_t[NCH];

    rst_seq #(
        .NUM_CH     (NCH),
        .STAGE_DLY  (SD),
        .LOCK_FILT  (LF),
        .WDT_CYCLES (WDT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pll_lock (pll_lock),
        .ch_hold  (ch_hold),
        .sw_req   (sw_req),
        .wdt_kick (wdt_kick),
        .ch_reset (ch_reset),
        .all_done (all_done),
        .wdt_flag (wdt_flag),
        .state_o  (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges are numbered from the SEQ entry edge (0). Channel k is released at
    // the first edge t, at least SD after the previous release, for which its
    // hold bit was clear on each of the last SD edges.
    task automatic run_sequence(input string name, input int mode, input int bound);
        logic [NCH-1:0] hist[$];
        logic [NCH-1:0] h;
        logic [NCH-1:0] exp_rst;
        logic [1:0]     exp_st;
        int k, prev, t;
        bit clr;
        hist = {};
        k = 0; prev = 0; t = 0;
        for (int j = 0; j < NCH; j++) rel_t[j] = -1;
        while (k < NCH && t < bound) begin
            h = '0;
            if (mode == 1 && t + 1 <= 10) h[1] = 1'b1;
            if (mode == 2)
                for (int j = 0; j < NCH; j++) h[j] = ($urandom_range(3) == 0);
            ch_hold = h;
            hist.push_back(h);
            step();
            t++;
            if (t - prev >= SD) begin
                clr = 1'b1;
                for (int i = t - SD + 1; i <= t; i++)
                    if (hist[i-1][k]) clr = 1'b0;
                if (clr) begin
                    rel_t[k] = t;
                    prev = t;
                    k++;
                end
            end
            for (int j = 0; j < NCH; j++) exp_rst[j] = (j >= k);
            exp_st = (k == NCH) ? S_RUN : S_SEQ;
            n_checks++;
            if (ch_reset !== exp_rst)
                $display("FAIL %s_ch_reset: edge %0d got %b expected %b", name, t, ch_reset, exp_rst);
            else n_pass++;
            n_checks++;
            if (state_o !== exp_st || all_done !== (k == NCH))
                $display("FAIL %s_state: edge %0d got state %0d done %b expected state %0d done %b",
                         name, t, state_o, all_done, exp_st, (k == NCH));
            else n_pass++;
        end
        ch_hold = '0;
        n_checks++;
        if (k != NCH)
            $display("FAIL %s_timeout: released %0d of %0d channels in %0d edges", name, k, NCH, bound);
        else n_pass++;
    endtask

    task automatic check_times(input string name, input int t0, input int t1, input int t2);
        n_checks++;
        if (rel_t[0] !== t0 || rel_t[1] !== t1 || rel_t[2] !== t2)
            $display("FAIL %s_times: got %0d,%0d,%0d expected %0d,%0d,%0d",
                     name, rel_t[0], rel_t[1], rel_t[2], t0, t1, t2);
        else n_pass++;
    endtask

    task automatic wait_for_seq(input string name, input int bound, output int edges);
        edges = 0;
        while (state_o !== S_SEQ && edges < bound) begin
            step();
            edges++;
        end
        n_checks++;
        if (state_o !== S_SEQ)
            $display("FAIL %s_wait_seq: state %0d after %0d edges, expected %0d", name, state_o, edges, S_SEQ);
        else n_pass++;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (ch_reset !== 3'b111 || all_done !== 1'b0 || wdt_flag !== 1'b0 || state_o !== S_WAIT)
            $display("FAIL reset_values: ch_reset %b done %b wdt %b state %0d expected 111 0 0 0",
                     ch_reset, all_done, wdt_flag, state_o);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            step();
            n_checks++;
            if (ch_reset !== 3'b111 || state_o !== S_WAIT)
                $display("FAIL reset_idle: ch_reset %b state %0d expected 111 0", ch_reset, state_o);
            else n_pass++;
        end
    endtask

    task automatic test_lock_seq();
        pll_lock = 1'b1;
        for (int e = 1; e <= LF + 3; e++) begin
            step();
            n_checks++;
            if (state_o !== ((e < LF + 3) ? S_WAIT : S_SEQ) || ch_reset !== 3'b111)
                $display("FAIL lock_entry: edge %0d state %0d ch_reset %b expected state %0d ch_reset 111",
                         e, state_o, ch_reset, (e < LF + 3) ? S_WAIT : S_SEQ);
            else n_pass++;
        end
        run_sequence("lock_seq", 0, 100);
        check_times("lock_seq", SD, 2 * SD, 3 * SD);
    endtask

    task automatic test_lock_loss();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        step();
        n_checks++;
        if (state_o !== S_RUN || ch_reset !== 3'b000)
            $display("FAIL lock_loss_early: state %0d ch_reset %b expected 2 000", state_o, ch_reset);
        else n_pass++;
        step();
        n_checks++;
        if (state_o !== S_WAIT || ch_reset !== 3'b111 || all_done !== 1'b0)
            $display("FAIL lock_loss: state %0d ch_reset %b done %b expected 0 111 0", state_o, ch_reset, all_done);
        else n_pass++;
        for (int e = 1; e <= LF + 1; e++) begin
            step();
            n_checks++;
            if (state_o !== ((e <= LF) ? S_WAIT : S_SEQ))
                $display("FAIL relock: edge %0d state %0d expected %0d", e, state_o, (e <= LF) ? S_WAIT : S_SEQ);
            else n_pass++;
        end
        run_sequence("relock_seq", 0, 100);
        check_times("relock_seq", SD, 2 * SD, 3 * SD);
    endtask

    task automatic pulse_sw(input string name);
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        n_checks++;
        if (state_o !== S_SEQ || ch_reset !== 3'b111 || all_done !== 1'b0)
            $display("FAIL %s_restart: state %0d ch_reset %b done %b expected 1 111 0",
                     name, state_o, ch_reset, all_done);
        else n_pass++;
    endtask

    task automatic test_hold();
        pulse_sw("hold");
        run_sequence("hold", 1, 100);
        check_times("hold", SD, 10 + SD, 10 + 2 * SD);
    endtask

    task automatic test_sw_req();
        int w;
        for (int r = 0; r < 4; r++) begin
            w = $urandom_range(15);
            repeat (w) step();
            n_checks++;
            if (state_o !== S_RUN || ch_reset !== 3'b000 || all_done !== 1'b1)
                $display("FAIL sw_run_idle: state %0d ch_reset %b done %b expected 2 000 1",
                         state_o, ch_reset, all_done);
            else n_pass++;
            pulse_sw("sw_run");
            run_sequence("sw_rand", 2, 300);
        end
        pulse_sw("sw_pre");
        w = $urandom_range(3 * SD - 1, 1);
        repeat (w) step();
        pulse_sw("sw_mid_seq");
        run_sequence("sw_mid_seq", 0, 100);
        check_times("sw_mid_seq", SD, 2 * SD, 3 * SD);
    endtask

    task automatic test_sw_lock_drop();
        int edges;
        pll_lock = 1'b0;
        step();
        step();
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        pll_lock = 1'b1;
        n_checks++;
        if (state_o !== S_WAIT || ch_reset !== 3'b111 || all_done !== 1'b0)
            $display("FAIL sw_lock_drop: state %0d ch_reset %b done %b expected 0 111 0",
                     state_o, ch_reset, all_done);
        else n_pass++;
        wait_for_seq("sw_lock_drop", 20, edges);
        run_sequence("sw_lock_drop_seq", 0, 100);
    endtask

    task automatic test_async_reset();
        int edges;
        pulse_sw("areset");
        repeat (SD + 1) step();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (ch_reset !== 3'b111 || state_o !== S_WAIT || all_done !== 1'b0 || wdt_flag !== 1'b0)
            $display("FAIL async_reset: ch_reset %b state %0d done %b wdt %b expected 111 0 0 0",
                     ch_reset, state_o, all_done, wdt_flag);
        else n_pass++;
        reset_n = 1'b1;
        wait_for_seq("async_relock", 20, edges);
        n_checks++;
        if (edges !== LF + 3)
            $display("FAIL async_relock_latency: got %0d edges expected %0d", edges, LF + 3);
        else n_pass++;
        run_sequence("async_seq", 0, 100);
    endtask

`ifdef RST_SEQ_WDT_EN
    task automatic test_wdt();
        for (int e = 1; e <= WDT; e++) begin
            step();
            n_checks++;
            if (state_o !== ((e < WDT) ? S_RUN : S_SEQ) || wdt_flag !== (e >= WDT))
                $display("FAIL wdt_expire: edge %0d state %0d flag %b expected %0d %b",
                         e, state_o, wdt_flag, (e < WDT) ? S_RUN : S_SEQ, (e >= WDT));
            else n_pass++;
        end
        run_sequence("wdt_reseq", 0, 100);
        for (int e = 1; e <= 100; e++) begin
            wdt_kick = ((e % 10 == 0) && e <= 60) || (e == 80);
            step();
            wdt_kick = 1'b0;
            n_checks++;
            if (state_o !== ((e < 100) ? S_RUN : S_SEQ) || wdt_flag !== 1'b1)
                $display("FAIL wdt_kick: edge %0d state %0d flag %b expected %0d 1",
                         e, state_o, wdt_flag, (e < 100) ? S_RUN : S_SEQ);
            else n_pass++;
        end
    endtask
`else
    task automatic test_wdt();
        for (int e = 1; e <= 2 * WDT; e++) begin
            wdt_kick = $urandom_range(1);
            step();
            n_checks++;
            if (state_o !== S_RUN || wdt_flag !== 1'b0 || ch_reset !== 3'b000)
                $display("FAIL wdt_absent: edge %0d state %0d flag %b ch_reset %b expected 2 0 000",
                         e, state_o, wdt_flag, ch_reset);
            else n_pass++;
        end
        wdt_kick = 1'b0;
    endtask
`endif

    initial begin
        reset_n  = 1'b0;
        pll_lock = 1'b0;
        ch_hold  = '0;
        sw_req   = 1'b0;
        wdt_kick = 1'b0;
        test_reset();
        test_lock_seq();
        test_lock_loss();
        test_hold();
        test_sw_req();
        test_sw_lock_drop();
        test_async_reset();
        test_wdt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
